uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART_TR transmitter among NUM_REQ byte producers. It round-robin
//   arbitrates their requests, launches one byte per grant via uart_tx_en and
//   uart_tx_data, then waits for uart_tx_done. It supports bounded burst hold and
//   a done-timeout watchdog. It sits between client logic and the UART_TR instance.
// PARAMETERS
//   NUM_REQ        4            number of requesters, 2..8
//   WIDTH          8            data width per requester; matches UART_TR width
//   BPS            9_600        line rate; used only for the timeout default
//   SYS_CLK_FREQ   50_000_000   sys_clk frequency in Hz
//   MAX_BURST      4            max consecutive bytes per owner while holding, >=1
//   TIMEOUT_CYCLES 12*SYS_CLK_FREQ/BPS   WAIT cycles before abandoning a byte
// PORTS
//   sys_clk       in   1              system clock; all logic on its rising edge
//   sys_reset     in   1              asynchronous, active-high reset
//   req_valid     in   NUM_REQ        per-requester byte pending
//   req_data      in   NUM_REQ*WIDTH  packed bytes; requester i uses [i*WIDTH +: WIDTH]
//   req_hold      in   NUM_REQ        request to keep the grant for the next byte
//   req_ack       out  NUM_REQ        one-hot 1-cycle pulse: byte captured
//   uart_tx_en    out  1              1-cycle launch pulse to UART_TR
//   uart_tx_data  out  WIDTH          byte to UART_TR; stable from SEND until next SEND
//   uart_tx_done  in   1              UART_TR frame-complete pulse
//   busy          out  1              high in every state except IDLE
//   grant_id      out  $clog2(NUM_REQ)   current or last owner index
//   timeout_err   out  1              1-cycle pulse when the watchdog fires
// BEHAVIOUR
//   Reset:
//     - State IDLE; all outputs 0.
//     - rr_ptr=0, burst_cnt=0, wd_cnt=0.
//     - Async assert mid-frame aborts at once; no ack or done is generated.
//   Handshake:
//     - A requester holds req_valid and its data stable until it sees req_ack.
//     - It may change both in the cycle after req_ack.
//   FSM:
//     - IDLE: if any req_valid, winner = first set bit at or after rr_ptr, wrapping.
//       Latch data and grant_id. Set owner_hold = req_hold[winner]. burst_cnt=1.
//       Next state SEND.
//     - SEND (exactly 1 cycle): uart_tx_en=1, req_ack[grant_id]=1.
//       wd_cnt=0. Next state WAIT.
//     - WAIT: wd_cnt increments each cycle.
//       - On uart_tx_done, if owner_hold && req_valid[grant_id] && burst_cnt<MAX_BURST:
//         regrant the same owner without arbitration. Latch new data and new hold,
//         increment burst_cnt, go to SEND. rr_ptr is unchanged.
//       - Otherwise on uart_tx_done: rr_ptr=grant_id+1 mod NUM_REQ, burst_cnt=0, go to IDLE.
//       - If wd_cnt==TIMEOUT_CYCLES-1 and there is no done: timeout_err=1,
//         rr_ptr advances past the owner, burst cleared, go to IDLE.
//   Latency:
//     - req_valid seen in IDLE at edge k gives SEND in cycle k+1.
//     - The regrant after done also reaches SEND in the next cycle.
//     - Minimum spacing is therefore frame time + 2 cycles.
//   Boundary conditions:
//     - uart_tx_done arriving in IDLE or SEND is ignored.
//     - done and timeout in the same cycle: done wins, no error.
//     - A req_valid drop while not yet granted simply withdraws the request.
//     - rr_ptr wraps at NUM_REQ-1 -> 0.
//     - burst_cnt saturates at MAX_BURST, which forces release.
//   Arithmetic:
//     - wd_cnt width is $clog2(TIMEOUT_CYCLES+1), unsigned.
//     - grant_id and rr_ptr width is $clog2(NUM_REQ).
// STRUCTURE
//   Shared package uart_pkg:
//     - FSM state encoding (IDLE, SEND, WAIT).
//     - Default BPS, SYS_CLK_FREQ and WIDTH.
//     - TIMEOUT_CYCLES calculation function.
//   Sub-module rr_picker: combinational (req vector, rr_ptr) -> winner index + any_valid.
//   Everything else (FSM, counters, data latch) stays in this module.
// TESTING
//   1. Single requester: req 1 with 0x55, hold=0 -> ack[1] and uart_tx_en
//      in the same cycle, uart_tx_data=0x55, rr_ptr=2 after done.
//   2. All 4 requesting continuously, hold=0, rr_ptr=0 -> grant order 0,1,2,3,0;
//      exactly one ack per frame.
//   3. Req 2 with hold=1, 6 bytes queued, MAX_BURST=4 -> 4 back-to-back grants
//      to 2, then a grant to requester 3 if pending.
//   4. No uart_tx_done after SEND -> timeout_err pulses TIMEOUT_CYCLES cycles
//      after SEND, then IDLE; next grant goes to the next requester.
//   5. Assert sys_reset during WAIT -> all outputs 0 immediately; after release
//      a pending req 0 is granted first.
//   6. uart_tx_done pulsed in IDLE -> no state change, no ack, busy stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM encoding,
// default line/clock settings and the watchdog length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int DEF_BPS          = 9_600;
    localparam int DEF_SYS_CLK_FREQ = 50_000_000;
    localparam int DEF_WIDTH        = 8;

    // A UART frame is at most ~12 bit times; the watchdog allows one frame.
    function automatic int timeout_cycles(input int sys_clk_freq, input int bps);
        longint prod;
        prod = longint'(12) * longint'(sys_clk_freq);
        return int'(prod / longint'(bps));
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first asserted request at or
// after rr_ptr (wrapping), plus a flag telling whether any request is set.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_valid
);

    localparam int IW = $clog2(NUM_REQ);

    // Scan from the farthest offset back to rr_ptr so the nearest request wins.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// arbitration, optional burst hold bounded by MAX_BURST, and a watchdog that
// abandons a byte whose frame-complete pulse never arrives.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// SEND  | one-cycle launch pulse and ack to the owner
// WAIT  | frame in flight; wait for done or watchdog expiry
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BPS            = DEF_BPS,
    parameter int SYS_CLK_FREQ   = DEF_SYS_CLK_FREQ,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = timeout_cycles(SYS_CLK_FREQ, BPS)
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_hold,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       uart_tx_en,
    output logic [WIDTH-1:0]           uart_tx_data,
    input  logic                       uart_tx_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int IW  = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW  = $clog2(MAX_BURST + 1);

    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [IW-1:0]  LAST_ID   = IW'(NUM_REQ - 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]    grant_nxt, pick;
    logic [BW-1:0]    burst_cnt, burst_nxt;
    logic [WDW-1:0]   wd_cnt, wd_nxt;
    logic             owner_hold, hold_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic             any_valid;

    function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
        return (id == LAST_ID) ? '0 : id + 1'b1;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (pick),
        .any_valid (any_valid)
    );

    assign uart_tx_en = (state == ST_SEND);
    assign req_ack    = (state == ST_SEND) ? (NUM_REQ'(1) << grant_id) : '0;
    assign busy       = (state != ST_IDLE);

    // Next-state, arbitration, burst and watchdog decisions.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        grant_nxt   = grant_id;
        burst_nxt   = burst_cnt;
        wd_nxt      = wd_cnt;
        hold_nxt    = owner_hold;
        data_nxt    = uart_tx_data;
        timeout_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    grant_nxt = pick;
                    data_nxt  = req_data[pick*WIDTH +: WIDTH];
                    hold_nxt  = req_hold[pick];
                    burst_nxt = BW'(1);
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                wd_nxt    = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                wd_nxt = wd_cnt + 1'b1;
                // done takes priority over a watchdog expiry in the same cycle
                if (uart_tx_done) begin
                    if (owner_hold && req_valid[grant_id] && (burst_cnt < BURST_MAX)) begin
                        data_nxt  = req_data[grant_id*WIDTH +: WIDTH];
                        hold_nxt  = req_hold[grant_id];
                        burst_nxt = burst_cnt + 1'b1;
                        state_nxt = ST_SEND;
                    end else begin
                        rr_ptr_nxt = next_id(grant_id);
                        burst_nxt  = '0;
                        state_nxt  = ST_IDLE;
                    end
                end else if (wd_cnt == WD_LAST) begin
                    timeout_err = 1'b1;
                    rr_ptr_nxt  = next_id(grant_id);
                    burst_nxt   = '0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner bookkeeping and latched byte.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            burst_cnt    <= '0;
            wd_cnt       <= '0;
            owner_hold   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            grant_id     <= grant_nxt;
            burst_cnt    <= burst_nxt;
            wd_cnt       <= wd_nxt;
            owner_hold   <= hold_nxt;
            uart_tx_data <= data_nxt;
        end
    end

endmodule
